// File: rtl/h2bp.sv
// rtl/h2bp.sv - shared fetch types: word_t, fetch_pkt_t and NOP_INSTR
package h2bp;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_pkt_t;

  localparam word_t NOP_INSTR = 32'h0;

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - shift-register fetch FIFO; head is slot 0, flush beats push
module fetch_buf
  import h2bp::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_pkt_t    din,
  output logic [CW-1:0] count,
  output fetch_pkt_t    head
);

  fetch_pkt_t    mem_q [DEPTH];
  fetch_pkt_t    mem_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] wr_idx;
  logic          do_pop;

  // Slot 0 is only overwritten by a shift or a push, so an emptied FIFO keeps its last head.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    do_pop  = pop && (count_q != '0);
    wr_idx  = count_q - {{(CW-1){1'b0}}, do_pop};
    if (flush) begin
      count_d = '0;
    end else begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (do_pop && (i + 1 < int'(count_q))) mem_d[i] = mem_q[i+1];
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_idx == CW'(i))) mem_d[i] = din;
      end
      count_d = wr_idx + {{(CW-1){1'b0}}, push};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '{pc: '0, instr: NOP_INSTR};
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[0];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, imem request credit and redirect; FETCH_PERF_CNT_EN adds perf counters
module fetch_unit
  import h2bp::*;
#(
  parameter word_t RESET_PC   = 32'd0,
  parameter int    FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int            CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);

  word_t         pc_q, pc_d;
  word_t         inflight_pc_q, inflight_pc_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          pop, issue, push;
  fetch_pkt_t    head;

  assign pop  = out_valid & out_ready;
  // Slots already committed next cycle; issuing only below depth makes overflow impossible.
  assign occ   = {1'b0, count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, inflight_q};
  assign issue = (occ < DEPTH_W) && !redirect_valid;
  assign push  = inflight_q && !redirect_valid;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
      pc_d          = pc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_buf #(
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ('{pc: inflight_pc_q, instr: imem_instr}),
    .count (count),
    .head  (head)
  );

  assign imem_pc   = pc_q;
  assign out_valid = (count != '0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    fetched_d = fetched_q;
    stall_d   = stall_q;
    if (pop && (fetched_q != '1)) fetched_d = fetched_q + 32'd1;
    if (out_valid && !out_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit: stream, stall, redirects, wrap, async reset
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_pc, imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr;

  logic [31:0] w_imem_pc, w_imem_instr;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = 32'd0;
  logic        w_out_valid;
  logic        w_out_ready = 1'b1;
  logic [31:0] w_out_pc, w_out_instr;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall, w_perf_fetched, w_perf_stall;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sb_exp;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'd0), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFE), .FIFO_DEPTH(2)) dut_w (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_pc        (w_imem_pc),
    .imem_instr     (w_imem_instr),
    .redirect_valid (w_redirect_valid),
    .redirect_pc    (w_redirect_pc),
    .out_valid      (w_out_valid),
    .out_ready      (w_out_ready),
    .out_pc         (w_out_pc),
    .out_instr      (w_out_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (w_perf_fetched),
    .perf_stall     (w_perf_stall)
`endif
  );

  // One-cycle imem: data for the pc sampled at the previous posedge.
  always @(posedge clk) begin
    imem_instr   <= imem_pc ^ 32'hA5A5_0000;
    w_imem_instr <= w_imem_pc ^ 32'hA5A5_0000;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual pc %h required none", out_pc);
      end else begin
        sb_exp = exp_q.pop_front();
        chk("sb_pc", out_pc, sb_exp);
        chk("sb_instr", out_instr, sb_exp ^ 32'hA5A5_0000);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_imem_pc", imem_pc, 32'd0);

    foreach (exp_q[i]) exp_q.delete(i);
    exp_q = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd40, 32'd41, 32'd42,
              32'd20, 32'd21, 32'd22, 32'd23, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    rst_n = 1'b1;

    for (int c = 0; c < 28; c++) begin
      out_ready      = !((c >= 4 && c <= 9) || c == 13 || c >= 26);
      redirect_valid = (c == 13 || c == 18 || c == 19);
      redirect_pc    = (c == 13) ? 32'd40 : (c == 18) ? 32'd10 : 32'd20;
      case (c)
        0: begin
          chk("c0_imem_pc", imem_pc, 32'd0);
          chk("c0_valid", 32'(out_valid), 32'd0);
        end
        1: chk("c1_valid", 32'(out_valid), 32'd0);
        2: begin
          chk("c2_valid", 32'(out_valid), 32'd1);
          chk("c2_out_pc", out_pc, 32'd0);
        end
        4, 5, 6, 7, 8, 9: begin
          chk("stall_imem_pc", imem_pc, 32'd4);
          chk("stall_out_pc", out_pc, 32'd2);
        end
`ifdef FETCH_PERF_CNT_EN
        12: begin
          chk("perf_fetched_c12", perf_fetched, 32'd4);
          chk("perf_stall_c12", perf_stall, 32'd6);
        end
`endif
        14, 15, 19, 20, 21: chk("redir_gap_valid", 32'(out_valid), 32'd0);
        16: begin
          chk("redir40_valid", 32'(out_valid), 32'd1);
          chk("redir40_pc", out_pc, 32'd40);
`ifdef FETCH_PERF_CNT_EN
          chk("perf_fetched_c16", perf_fetched, 32'd5);
          chk("perf_stall_c16", perf_stall, 32'd7);
`endif
        end
        22: begin
          chk("redir20_valid", 32'(out_valid), 32'd1);
          chk("redir20_pc", out_pc, 32'd20);
        end
        27: begin
          chk("full_valid", 32'(out_valid), 32'd1);
          rst_n = 1'b0;
          #1;
          chk("async_rst_valid", 32'(out_valid), 32'd0);
          chk("async_rst_out_pc", out_pc, 32'd0);
          chk("async_rst_imem_pc", imem_pc, 32'd0);
          chk("async_rst_w_valid", 32'(w_out_valid), 32'd0);
        end
        default: ;
      endcase
      @(posedge clk);
      #1;
    end

    @(posedge clk);
    #1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    rst_n          = 1'b1;
    for (int c = 0; c < 8; c++) begin
      case (c)
`ifdef FETCH_PERF_CNT_EN
        0: begin
          chk("perf_fetched_rst", perf_fetched, 32'd0);
          chk("perf_stall_rst", perf_stall, 32'd0);
        end
`endif
        1: chk("r_c1_valid", 32'(out_valid), 32'd0);
        2: begin
          chk("r_c2_valid", 32'(out_valid), 32'd1);
          chk("r_c2_out_pc", out_pc, 32'd0);
          chk("wrap_valid", 32'(w_out_valid), 32'd1);
          chk("wrap_pc0", w_out_pc, 32'hFFFF_FFFE);
        end
        3: chk("wrap_pc1", w_out_pc, 32'hFFFF_FFFF);
        4: chk("wrap_pc2", w_out_pc, 32'h0000_0000);
        5: begin
          chk("wrap_pc3", w_out_pc, 32'h0000_0001);
          chk("wrap_instr3", w_out_instr, 32'hA5A5_0001);
        end
        default: ;
      endcase
      @(posedge clk);
      #1;
    end

    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
